// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-mode PWM LED pattern engine.
// A free-running PWM counter times every channel. A phase accumulator
// advances once per PWM frame. Each channel's duty comes from the phase,
// the active mode and a global brightness scale. Mode requests are held
// pending and only take effect on a phase wrap, so a mode change never
// cuts a pattern period short.
module led_pattern_gen #(
  parameter int N_LED    = 8,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                mode_vld,
  input  logic [3:0]          speed,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LED-1:0]    led,
  output logic                period_tick
);

  localparam int PH_W    = PWM_BITS + 1;             // phase accumulator width
  localparam int LOG_N   = $clog2(N_LED);
  localparam int CH_STEP = (1 << PH_W) / N_LED;      // phase offset between channels

  localparam logic [1:0] MODE_WAVE    = 2'd0;
  localparam logic [1:0] MODE_BREATHE = 2'd1;
  localparam logic [1:0] MODE_CHASE   = 2'd2;
  localparam logic [1:0] MODE_STATIC  = 2'd3;

  localparam logic [0:0] ST_RUN  = 1'b0;             // no request outstanding
  localparam logic [0:0] ST_PEND = 1'b1;             // request waiting for a wrap

  logic [PWM_BITS-1:0] r_pwm_ctr;
  logic [PH_W-1:0]     r_phase;
  logic                r_period_tick;
  logic [0:0]          r_state;
  logic [1:0]          r_pend_mode;
  logic [1:0]          r_active_mode;
  logic [N_LED-1:0]    r_led;

  logic                w_frame_end;
  logic [PH_W:0]       w_step;
  logic [PH_W:0]       w_phase_sum;
  logic                w_wrap;
  logic [PWM_BITS-1:0] w_tri0;
  logic [LOG_N-1:0]    w_chase_idx;
  logic [N_LED-1:0]    w_on;

  assign w_frame_end = (r_pwm_ctr == '1);
  assign w_step      = (PH_W+1)'(speed) + (PH_W+1)'(1);
  assign w_phase_sum = {1'b0, r_phase} + w_step;
  // Carry out of the accumulator on a frame step is the period wrap.
  assign w_wrap      = w_frame_end & w_phase_sum[PH_W];

  // Free-running PWM counter; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) r_pwm_ctr <= '0;
    else        r_pwm_ctr <= r_pwm_ctr + 1'b1;
  end

  // Phase advances by speed+1 at the end of each PWM frame; wrap pulses tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_period_tick <= w_wrap;
      if (w_frame_end) r_phase <= w_phase_sum[PH_W-1:0];
    end
  end

  // Mode request FSM: requests wait for a phase wrap; the last request wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pend_mode   <= MODE_WAVE;
      r_active_mode <= MODE_WAVE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mode_vld) begin
            r_pend_mode <= mode;
            r_state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          // A strobe landing on the wrap cycle applies the older request and
          // keeps the new one pending for the following wrap.
          if (w_wrap)              r_active_mode <= r_pend_mode;
          if (mode_vld)            r_pend_mode   <= mode;
          if (w_wrap && !mode_vld) r_state       <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Channel 0 triangle drives every channel in BREATHE; chase index is phase MSBs.
  assign w_tri0      = r_phase[PH_W-1] ? ~r_phase[PWM_BITS-1:0] : r_phase[PWM_BITS-1:0];
  assign w_chase_idx = r_phase[PH_W-1 -: LOG_N];

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    logic [PH_W-1:0]       w_ph;
    logic [PWM_BITS-1:0]   w_tri;
    logic [PWM_BITS-1:0]   w_raw;
    logic [2*PWM_BITS-1:0] w_prod;
    logic [PWM_BITS-1:0]   w_duty;

    assign w_ph  = r_phase + PH_W'(g * CH_STEP);
    assign w_tri = w_ph[PH_W-1] ? ~w_ph[PWM_BITS-1:0] : w_ph[PWM_BITS-1:0];

    // Raw duty for this channel in the active mode.
    always_comb begin
      // NOTE: a default assignment first keeps every path assigned, so no
      // latch is inferred if the case below is ever incomplete.
      w_raw = '0;
      case (r_active_mode)
        MODE_WAVE:    w_raw = w_tri;
        MODE_BREATHE: w_raw = w_tri0;
        MODE_CHASE:   w_raw = (w_chase_idx == LOG_N'(g)) ? '1 : '0;
        MODE_STATIC:  w_raw = '1;
        default:      w_raw = '0;
      endcase
    end

    // Full brightness bypasses the multiplier so full duty stays exact.
    assign w_prod  = {{PWM_BITS{1'b0}}, w_raw} * {{PWM_BITS{1'b0}}, brightness};
    assign w_duty  = (brightness == '1) ? w_raw : w_prod[2*PWM_BITS-1:PWM_BITS];
    assign w_on[g] = (w_duty > r_pwm_ctr);
  end

  // Registered LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_led <= '0;
    else        r_led <= w_on;
  end

  assign led         = r_led;
  assign period_tick = r_period_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LED=4, PWM_BITS=4.
// Edges are numbered from reset release; outputs are sampled on falling edges.
// Duty is measured as the count of high samples in a 16-cycle window.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       mode_vld;
  logic [3:0] speed;
  logic [3:0] brightness;
  logic [3:0] led;
  logic       period_tick;

  int checks   = 0;
  int failures = 0;
  int edge_cnt;
  int cnt [4];
  int tcnt;

  led_pattern_gen #(.N_LED(4), .PWM_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .mode_vld   (mode_vld),
    .speed      (speed),
    .brightness (brightness),
    .led        (led),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Rising-edge counter since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Move to the falling edge just after rising edge k.
  task automatic goto_edge(input int k);
    int guard = 0;
    while (edge_cnt != k && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("goto_edge_%0d", k), edge_cnt, k);
  endtask

  // Count high samples per LED (and ticks) over the next 16 falling edges.
  task automatic count_win();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    tcnt = 0;
    repeat (16) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (led[k]) cnt[k]++;
      if (period_tick) tcnt++;
    end
  endtask

  task automatic check_win(input string tag, input int e0, input int e1, input int e2, input int e3);
    count_win();
    check({tag, "_led0"}, cnt[0], e0);
    check({tag, "_led1"}, cnt[1], e1);
    check({tag, "_led2"}, cnt[2], e2);
    check({tag, "_led3"}, cnt[3], e3);
  endtask

  // Wait (bounded) for the next period_tick and check the edge it lands on.
  task automatic wait_tick(input string tag, input int exp_edge);
    int guard = 0;
    logic seen = 1'b0;
    while (!seen && guard < 700) begin
      @(negedge clk);
      guard++;
      if (period_tick) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_edge"}, edge_cnt, exp_edge);
  endtask

  task automatic strobe(input logic [1:0] m);
    mode     = m;
    mode_vld = 1'b1;
    @(negedge clk);
    mode_vld = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mode       = 2'd0;
    mode_vld   = 1'b0;
    speed      = 4'd0;
    brightness = 4'd15;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_led", led, 4'b0000);
    check("reset_tick", period_tick, 1'b0);
    rst_n = 1'b1;

    // WAVE at phase 0, pwm_ctr=4: duties {0,8,15,7} -> led=1110
    goto_edge(5);
    check("run_led_e5", led, 4'b1110);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_led", led, 4'b0000);
    check("async_rst_tick", period_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First frame after release: phase 0, tri = {0,8,15,7}
    check_win("wave_ph0", 0, 8, 15, 7);
    check("wave_ph0_ticks", tcnt, 0);

    // CHASE requested at edge 100; WAVE persists until the wrap at 512
    goto_edge(99);
    strobe(2'd2);
    goto_edge(480);
    check_win("wave_ph30", 1, 6, 14, 9);
    wait_tick("tick1", 512);
    @(negedge clk);
    check("tick_pulse_width", period_tick, 1'b0);

    // CHASE, speed 0: 128 clocks per LED
    goto_edge(528);
    check_win("chase_ph1", 15, 0, 0, 0);
    goto_edge(640);
    check_win("chase_ph8", 0, 15, 0, 0);
    goto_edge(768);
    check_win("chase_ph16", 0, 0, 15, 0);
    goto_edge(896);
    check_win("chase_ph24", 0, 0, 0, 15);
    wait_tick("tick2", 1024);

    // speed 3: wrap every 128 clocks; request WAVE
    speed = 4'd3;
    strobe(2'd0);
    wait_tick("tick3", 1152);
    goto_edge(1168);
    check_win("wave_s3_ph4", 4, 12, 11, 3);
    goto_edge(1200);
    check_win("wave_s3_ph12", 12, 11, 3, 4);
    wait_tick("tick4", 1280);

    // Two requests before the wrap: the last one (STATIC) wins
    strobe(2'd1);
    goto_edge(1290);
    strobe(2'd3);
    wait_tick("tick5", 1408);
    check_win("static_b15", 15, 15, 15, 15);
    brightness = 4'd8;
    check_win("static_b8", 7, 7, 7, 7);
    brightness = 4'd14;
    check_win("static_b14", 13, 13, 13, 13);
    brightness = 4'd0;
    check_win("static_b0", 0, 0, 0, 0);
    brightness = 4'd15;

    // WAVE pending, then BREATHE strobed on the wrap edge itself
    goto_edge(1480);
    strobe(2'd0);
    goto_edge(1535);
    strobe(2'd1);
    check("tick_coincident", period_tick, 1'b1);
    check_win("wave_after_coinc", 0, 8, 15, 7);
    wait_tick("tick7", 1664);
    goto_edge(1680);
    check_win("breathe_ph4", 4, 4, 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
